rng_sched: RTL and testbench

Request scheduler for the 8-bit LFSR random-number peripheral. It shares one LFSR among `NUM_REQ` requesters using round-robin arbitration, and gives priority to a single reseed channel. It drives the peripheral's register bus (address 0 = shift/read, address 1 = load) and returns each freshly shifted byte to the granted requester with a one-cycle acknowledge. It sits between on-chip consumers and the LFSR peripheral, and is the only master of that peripheral's bus.

---
 rtl/rng_sched.sv | 157 +++++++++++++++
 tb/tb_rng_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_sched.sv
// rtl/rng_sched.sv - round-robin request scheduler with reseed priority for the 8-bit LFSR peripheral
module rng_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [7:0]         rsp_data,
    input  logic               seed_valid,
    input  logic [7:0]         seed_data,
    output logic               seed_busy,
    output logic               seed_done,
    output logic [3:0]         rng_address,
    output logic               rng_data_write,
    output logic [7:0]         rng_data_in,
    input  logic [7:0]         rng_data_out,
    output logic [CNT_W-1:0]   served_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_LOAD
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_q;
    logic               pend_q, pend_d;
    logic [7:0]         seed_q, seed_d;
    logic [NUM_REQ-1:0] ack_q;
    logic [7:0]         rsp_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         addr_q;
    logic               wr_q;
    logic [7:0]         din_q;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   rr_cand;
    int                 rr_j;

    // Round-robin search starting one past the most recently acked requester
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        rr_j     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_j = int'(last_q) + i;
            if (rr_j >= NUM_REQ) begin
                rr_j = rr_j - NUM_REQ;
            end
            rr_cand = IDX_W'(rr_j);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Seed capture: a strobe always wins (last value wins); a LOAD retires the pending seed
    always_comb begin
        pend_d = pend_q;
        seed_d = seed_q;
        if (seed_valid) begin
            pend_d = 1'b1;
            seed_d = seed_data;
        end else if (state_q == S_LOAD) begin
            pend_d = 1'b0;
        end
    end

    // Pending seed storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            seed_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
            seed_q <= seed_d;
        end
    end

    // Scheduler FSM with registered bus decode, acknowledge and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            ack_q   <= '0;
            rsp_q   <= 8'h00;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= 4'd0;
            wr_q    <= 1'b0;
            din_q   <= 8'h00;
        end else begin
            ack_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_q <= S_LOAD;
                        wr_q    <= 1'b1;
                        addr_q  <= 4'd1;
                        din_q   <= seed_q;
                    end else if (rr_found) begin
                        state_q <= S_SHIFT;
                        grant_q <= rr_idx;
                        wr_q    <= 1'b1;
                        addr_q  <= 4'd0;
                        din_q   <= 8'h00;
                    end
                end
                S_SHIFT: begin
                    state_q <= S_CAPTURE;
                    wr_q    <= 1'b0;
                    addr_q  <= 4'd0;
                end
                S_CAPTURE: begin
                    state_q <= S_IDLE;
                    rsp_q   <= rng_data_out;
                    ack_q   <= NUM_REQ'(1) << grant_q;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    last_q  <= grant_q;
                end
                S_LOAD: begin
                    state_q <= S_IDLE;
                    wr_q    <= 1'b0;
                    addr_q  <= 4'd0;
                    din_q   <= 8'h00;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack            = ack_q;
    assign rsp_data       = rsp_q;
    assign seed_done      = done_q;
    assign seed_busy      = pend_q | (state_q == S_LOAD);
    assign served_cnt     = cnt_q;
    assign rng_address    = addr_q;
    assign rng_data_write = wr_q;
    assign rng_data_in    = din_q;

endmodule

// File: tb/tb_rng_sched.sv
// tb/tb_rng_sched.sv - self-checking bench for rng_sched with an LFSR peripheral model
module tb_rng_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic        seed_valid;
    logic [7:0]  seed_data;
    logic        seed_busy;
    logic        seed_done;
    logic [3:0]  rng_address;
    logic        rng_data_write;
    logic [7:0]  rng_data_in;
    logic [7:0]  rng_data_out;
    logic [15:0] served_cnt;

    int checks = 0;
    int errors = 0;
    int exp_served = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    logic [7:0] last_load = 8'h00;
    logic [7:0] lfsr;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] req;
        int         idx;
        logic [7:0] data;
        bit         drop;
        int         rmode;
    } vec_t;
    vec_t tbl[9];

    rng_sched #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .ack(ack),
        .rsp_data(rsp_data),
        .seed_valid(seed_valid),
        .seed_data(seed_data),
        .seed_busy(seed_busy),
        .seed_done(seed_done),
        .rng_address(rng_address),
        .rng_data_write(rng_data_write),
        .rng_data_in(rng_data_in),
        .rng_data_out(rng_data_out),
        .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    // LFSR peripheral: taps 8,6,5,4, shift on address 0 write, load on address 1 write
    assign rng_data_out = lfsr;
    always @(posedge clk) begin
        if (p_rst) begin
            lfsr <= 8'hAA;
        end else if (rng_data_write) begin
            if (rng_address == 4'd0) begin
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else if (rng_address == 4'd1) begin
                lfsr      <= rng_data_in;
                load_cnt  <= load_cnt + 1;
                last_load <= rng_data_in;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest expected entry
    always @(negedge clk) begin
        if (seed_done) done_cnt++;
        if (ack != 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
                exp_t e;
                logic [3:0] exp_ack;
                e = sb.pop_front();
                exp_ack = 4'b0001 << e.idx;
                exp_served++;
                chk("ack_index", ack, exp_ack);
                chk("rsp_data", rsp_data, e.data);
                chk("served_cnt", served_cnt, exp_served);
                chk("ack_done_excl", seed_done, 0);
            end
        end
    end

    task automatic wait_ack(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack != 4'b0000) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic do_reset(input bit both);
        @(negedge clk);
        rst = 1'b1;
        p_rst = both;
        @(negedge clk);
        rst = 1'b0;
        p_rst = 1'b0;
        exp_served = 0;
    endtask

    initial begin
        int c;
        int loads0;
        int dones0;

        tbl[0] = '{4'b0001, 0, 8'h55, 1'b1, 1};
        tbl[1] = '{4'b0001, 0, 8'h55, 1'b0, 1};
        tbl[2] = '{4'b0001, 0, 8'hAB, 1'b0, 0};
        tbl[3] = '{4'b0001, 0, 8'h57, 1'b1, 0};
        tbl[4] = '{4'b1111, 0, 8'hAF, 1'b0, 2};
        tbl[5] = '{4'b1111, 1, 8'h5F, 1'b0, 0};
        tbl[6] = '{4'b1111, 2, 8'hBE, 1'b0, 0};
        tbl[7] = '{4'b1111, 3, 8'h7C, 1'b0, 0};
        tbl[8] = '{4'b1111, 0, 8'hF9, 1'b1, 0};

        rst = 1'b1;
        p_rst = 1'b1;
        req = 4'b0000;
        seed_valid = 1'b0;
        seed_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_seed_busy", seed_busy, 0);
        chk("rst_seed_done", seed_done, 0);
        chk("rst_served_cnt", served_cnt, 0);
        chk("rst_write", rng_data_write, 0);
        chk("rst_address", rng_address, 0);
        chk("rst_data_in", rng_data_in, 0);
        rst = 1'b0;
        p_rst = 1'b0;

        // Table: single grant, continuous stream, and all-requesters rotation
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rmode != 0) do_reset(tbl[i].rmode == 1);
            sb.push_back('{tbl[i].idx, tbl[i].data});
            req = tbl[i].req;
            wait_ack(c);
            chk($sformatf("latency_%0d", i), c, 3);
            if (tbl[i].drop) req = 4'b0000;
        end

        // Seed arriving during SHIFT of req[1]; req[1] dropped mid-flight
        sb.push_back('{1, 8'hF2});
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        seed_valid = 1'b1;
        seed_data = 8'h01;
        @(negedge clk);
        seed_valid = 1'b0;
        chk("seed_busy_pending", seed_busy, 1);
        wait_ack(c);
        chk("ack_before_load", c, 1);
        chk("seed_busy_at_ack", seed_busy, 1);
        @(negedge clk);
        chk("load_address", rng_address, 1);
        chk("load_write", rng_data_write, 1);
        chk("load_data", rng_data_in, 8'h01);
        @(negedge clk);
        chk("seed_done_pulse", seed_done, 1);
        chk("seed_busy_clear", seed_busy, 0);
        chk("bus_idle_after_load", {rng_data_write, rng_address, rng_data_in}, 0);
        sb.push_back('{0, 8'h02});
        req = 4'b0001;
        wait_ack(c);
        chk("latency_after_seed", c, 3);
        req = 4'b0000;

        // Two seeds while busy: one LOAD with the last value
        loads0 = load_cnt;
        dones0 = done_cnt;
        sb.push_back('{0, 8'h04});
        req = 4'b0001;
        @(negedge clk);
        seed_valid = 1'b1;
        seed_data = 8'h10;
        @(negedge clk);
        seed_data = 8'h01;
        req = 4'b0000;
        wait_ack(c);
        seed_valid = 1'b0;
        chk("ack_with_two_seeds", c, 1);
        repeat (6) @(negedge clk);
        chk("single_load", load_cnt - loads0, 1);
        chk("load_last_wins", last_load, 8'h01);
        chk("single_done", done_cnt - dones0, 1);

        // Reset during CAPTURE aborts the request
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("abort_ack", ack, 0);
        chk("abort_served_cnt", served_cnt, 0);
        chk("abort_write", rng_data_write, 0);
        chk("abort_address", rng_address, 0);
        chk("abort_seed_busy", seed_busy, 0);
        chk("abort_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_served = 0;
        repeat (3) @(negedge clk);
        sb.push_back('{0, 8'h04});
        req = 4'b1111;
        wait_ack(c);
        chk("latency_after_abort", c, 3);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
